// File: rtl/kbd_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_scan_sequencer
//  Purpose  : Assembles raw PS/2 scan bytes (optional 0xE0 extended prefix,
//             optional 0xF0 release prefix, final code byte) into a single
//             10-bit key event {release, extended, code} on an AXI-Stream
//             style output. Prefix sequences that stall for PREFIX_TIMEOUT
//             cycles are abandoned. Malformed sequences and keyboard
//             overrun/error bytes (0x00, 0xFF) raise a one-cycle err_o pulse.
//  Ports    : axis_aclk_i      - clock, rising edge
//             axis_aresetn_i   - synchronous active-low reset
//             s_axis_tvalid_i  - raw byte valid
//             s_axis_tready_o  - sequencer accepts a raw byte
//             s_axis_tdata_i   - raw scan byte
//             m_axis_tvalid_o  - key event valid
//             m_axis_tready_i  - downstream accepts key event
//             m_axis_tdata_o   - {release, extended, code[7:0]}
//             err_o            - one-cycle protocol error / timeout pulse
//  Revision : 1.0 - initial release
// ============================================================================
module kbd_scan_sequencer #(
    parameter int PREFIX_TIMEOUT = 1000,
    parameter int CNT_WIDTH      = 10
) (
    input  logic       axis_aclk_i,
    input  logic       axis_aresetn_i,
    input  logic       s_axis_tvalid_i,
    output logic       s_axis_tready_o,
    input  logic [7:0] s_axis_tdata_i,
    output logic       m_axis_tvalid_o,
    input  logic       m_axis_tready_i,
    output logic [9:0] m_axis_tdata_o,
    output logic       err_o
);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_pfx_e0   = 3'd1;
    localparam logic [2:0] c_pfx_f0   = 3'd2;
    localparam logic [2:0] c_pfx_e0f0 = 3'd3;
    localparam logic [2:0] c_out      = 3'd4;

    localparam logic [7:0] c_byte_ext = 8'hE0;
    localparam logic [7:0] c_byte_rel = 8'hF0;
    localparam logic [7:0] c_byte_ovr = 8'h00;
    localparam logic [7:0] c_byte_err = 8'hFF;

    localparam logic [CNT_WIDTH-1:0] c_timeout_last = CNT_WIDTH'(PREFIX_TIMEOUT - 1);

    logic [2:0]           state_q,  state_d;
    logic [CNT_WIDTH-1:0] cnt_q,    cnt_d;
    logic                 tready_q, tready_d;
    logic                 tvalid_q, tvalid_d;
    logic [9:0]           tdata_q,  tdata_d;
    logic                 err_q,    err_d;

    logic w_accept;
    logic w_ext_flag;
    logic w_rel_flag;

    // tready_q is itself registered, so acceptance is a pure AND of the
    // incoming valid with what the sequencer advertised this cycle.
    assign w_accept   = s_axis_tvalid_i & tready_q;
    assign w_ext_flag = (state_q == c_pfx_e0) || (state_q == c_pfx_e0f0);
    assign w_rel_flag = (state_q == c_pfx_f0) || (state_q == c_pfx_e0f0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        err_d    = 1'b0;

        case (state_q)
            c_idle, c_pfx_e0, c_pfx_f0, c_pfx_e0f0: begin
                if (w_accept) begin
                    if (s_axis_tdata_i == c_byte_ext) begin
                        // A fresh 0xE0 always restarts the sequence; it is
                        // only an error if a prefix was already in flight.
                        state_d = c_pfx_e0;
                        err_d   = (state_q != c_idle);
                    end else if (s_axis_tdata_i == c_byte_rel) begin
                        if (state_q == c_idle) begin
                            state_d = c_pfx_f0;
                        end else if (state_q == c_pfx_e0) begin
                            state_d = c_pfx_e0f0;
                        end else begin
                            // Duplicate release prefix: keep waiting for code.
                            err_d = 1'b1;
                        end
                    end else if ((s_axis_tdata_i == c_byte_ovr) ||
                                 (s_axis_tdata_i == c_byte_err)) begin
                        state_d = c_idle;
                        err_d   = 1'b1;
                    end else begin
                        state_d  = c_out;
                        tvalid_d = 1'b1;
                        tdata_d  = {w_rel_flag, w_ext_flag, s_axis_tdata_i};
                    end
                end else if (state_q != c_idle) begin
                    // A byte landing on the last count wins over the timeout,
                    // because this branch is only reached without acceptance.
                    if (cnt_q == c_timeout_last) begin
                        state_d = c_idle;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            c_out: begin
                if (m_axis_tready_i) begin
                    state_d  = c_idle;
                    tvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = c_idle;
                tvalid_d = 1'b0;
            end
        endcase

        // Registered ready follows the next state so it is low for the whole
        // time an event is pending.
        tready_d = (state_d != c_out);
    end

    always_ff @(posedge axis_aclk_i) begin
        if (!axis_aresetn_i) begin
            state_q  <= c_idle;
            cnt_q    <= '0;
            tready_q <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tready_q <= tready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            err_q    <= err_d;
        end
    end

    assign s_axis_tready_o = tready_q;
    assign m_axis_tvalid_o = tvalid_q;
    assign m_axis_tdata_o  = tdata_q;
    assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_kbd_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kbd_scan_sequencer
//  Purpose  : Self-checking bench for kbd_scan_sequencer. Directed scenarios
//             check against constant expectations; a randomized scenario is
//             checked cycle by cycle against a flag-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_kbd_scan_sequencer;

    localparam int T  = 20;
    localparam int CW = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_tvalid = 1'b0;
    logic [7:0] s_tdata = 8'h00;
    logic       m_tready = 1'b0;
    logic       s_tready;
    logic       m_tvalid;
    logic [9:0] m_tdata;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Reference model: expected registered outputs plus the abstract
    // sequence status (inside a prefix, which prefixes seen, idle cycles).
    logic       exp_tready = 1'b0;
    logic       exp_tvalid = 1'b0;
    logic [9:0] exp_tdata  = 10'h000;
    logic       exp_err    = 1'b0;
    bit         m_in_pfx = 1'b0;
    bit         m_ext = 1'b0;
    bit         m_rel = 1'b0;
    int         m_wait = 0;

    kbd_scan_sequencer #(
        .PREFIX_TIMEOUT (T),
        .CNT_WIDTH      (CW)
    ) dut (
        .axis_aclk_i     (clk),
        .axis_aresetn_i  (rst_n),
        .s_axis_tvalid_i (s_tvalid),
        .s_axis_tready_o (s_tready),
        .s_axis_tdata_i  (s_tdata),
        .m_axis_tvalid_o (m_tvalid),
        .m_axis_tready_i (m_tready),
        .m_axis_tdata_o  (m_tdata),
        .err_o           (err)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model, then sample after the edge.
    task automatic step(input bit tv, input logic [7:0] td, input bit mr);
        logic       n_tvalid;
        logic [9:0] n_tdata;
        logic       n_err;
        s_tvalid = tv;
        s_tdata  = td;
        m_tready = mr;
        n_tvalid = exp_tvalid;
        n_tdata  = exp_tdata;
        n_err    = 1'b0;
        if (exp_tvalid) begin
            if (mr) n_tvalid = 1'b0;
        end else if (tv && exp_tready) begin
            if (td == 8'hE0) begin
                n_err = m_in_pfx;
                m_in_pfx = 1'b1; m_ext = 1'b1; m_rel = 1'b0;
            end else if (td == 8'hF0) begin
                if (!m_in_pfx) begin
                    m_in_pfx = 1'b1; m_ext = 1'b0; m_rel = 1'b1;
                end else if (m_ext && !m_rel) begin
                    m_rel = 1'b1;
                end else begin
                    n_err = 1'b1;
                end
            end else if (td == 8'h00 || td == 8'hFF) begin
                n_err = 1'b1;
                m_in_pfx = 1'b0;
            end else begin
                n_tvalid = 1'b1;
                n_tdata  = {m_in_pfx & m_rel, m_in_pfx & m_ext, td};
                m_in_pfx = 1'b0;
            end
            m_wait = 0;
        end else if (m_in_pfx) begin
            if (m_wait == T - 1) begin
                m_in_pfx = 1'b0;
                n_err = 1'b1;
            end else begin
                m_wait++;
            end
        end
        exp_tvalid = n_tvalid;
        exp_tdata  = n_tdata;
        exp_err    = n_err;
        exp_tready = !n_tvalid;
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, then releases it before the next edge.
    task automatic do_reset();
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_tready = 1'b0; exp_tvalid = 1'b0; exp_tdata = '0; exp_err = 1'b0;
        m_in_pfx = 1'b0; m_ext = 1'b0; m_rel = 1'b0; m_wait = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
        total++; if (m_tdata !== 10'h000) begin bad++; $display("FAIL reset_tdata: got %h want 000", m_tdata); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", s_tready); end
        step(0, 8'h00, 0);
        total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_tready_rise: got %b want 1", s_tready); end
    endtask

    task automatic test_plain_make();
        step(1, 8'h1C, 1);
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL make_latency: got %b want 1", m_tvalid); end
        total++; if (m_tdata !== 10'h01C) begin bad++; $display("FAIL make_data: got %h want 01c", m_tdata); end
        total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL make_tready_out: got %b want 0", s_tready); end
        step(0, 8'h00, 1);
        total++; if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin bad++; $display("FAIL make_done: got tvalid=%b tready=%b want 0/1", m_tvalid, s_tready); end
    endtask

    task automatic test_ext_release();
        int errs = 0;
        step(1, 8'hE0, 0); errs += int'(err);
        step(1, 8'hF0, 0); errs += int'(err);
        step(1, 8'h75, 0); errs += int'(err);
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 10'h375) begin bad++; $display("FAIL ext_rel_event: got v=%b d=%h want 1/375", m_tvalid, m_tdata); end
        step(0, 8'h00, 1); errs += int'(err);
        total++; if (errs != 0) begin bad++; $display("FAIL ext_rel_err: got %0d pulses want 0", errs); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL ext_rel_done: got %b want 0", m_tvalid); end
    endtask

    task automatic test_backpressure();
        int held_bad = 0;
        int hs = 0;
        step(1, 8'hF0, 0);
        step(1, 8'h1C, 0);
        for (int i = 0; i < 20; i++) begin
            if (m_tvalid !== 1'b1 || m_tdata !== 10'h21C || s_tready !== 1'b0) held_bad++;
            step(1, 8'($urandom_range(1, 254)), 0);
        end
        total++; if (held_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", held_bad); end
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 10'h21C) begin bad++; $display("FAIL bp_pre_hs: got v=%b d=%h want 1/21c", m_tvalid, m_tdata); end
        for (int i = 0; i < 4; i++) begin
            if (m_tvalid === 1'b1) hs++;
            step(0, 8'h00, 1);
        end
        total++; if (hs != 1) begin bad++; $display("FAIL bp_handshakes: got %0d want 1", hs); end
    endtask

    task automatic test_timeout();
        int errs = 0;
        step(1, 8'hE0, 0);
        for (int i = 0; i < T; i++) begin
            step(0, 8'h00, 0);
            errs += int'(err);
        end
        step(1, 8'h1C, 0); errs += int'(err);
        total++; if (errs != 1) begin bad++; $display("FAIL timeout_err: got %0d pulses want 1", errs); end
        total++; if (m_tvalid !== 1'b1 || m_tdata !== 10'h01C) begin bad++; $display("FAIL timeout_event: got v=%b d=%h want 1/01c", m_tvalid, m_tdata); end
        step(0, 8'h00, 1);
        // Byte arriving on the last allowed cycle beats the timeout.
        errs = 0;
        step(1, 8'hE0, 0);
        for (int i = 0; i < T - 1; i++) begin
            step(0, 8'h00, 0);
            errs += int'(err);
        end
        step(1, 8'h1C, 0); errs += int'(err);
        total++; if (errs != 0) begin bad++; $display("FAIL timeout_edge_err: got %0d pulses want 0", errs); end
        total++; if (m_tdata !== 10'h11C) begin bad++; $display("FAIL timeout_edge_event: got %h want 11c", m_tdata); end
        step(0, 8'h00, 1);
    endtask

    task automatic test_error_bytes();
        step(1, 8'hF0, 0);
        step(1, 8'hFF, 0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL errbyte_pulse: got %b want 1", err); end
        step(1, 8'h1C, 0);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL errbyte_pulse_width: got %b want 0", err); end
        total++; if (m_tdata !== 10'h01C || m_tvalid !== 1'b1) begin bad++; $display("FAIL errbyte_event: got v=%b d=%h want 1/01c", m_tvalid, m_tdata); end
        step(0, 8'h00, 1);
        step(1, 8'hF0, 0);
        step(1, 8'hF0, 0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL dup_f0_pulse: got %b want 1", err); end
        step(1, 8'h1C, 0);
        total++; if (m_tdata !== 10'h21C) begin bad++; $display("FAIL dup_f0_stay: got %h want 21c", m_tdata); end
        step(0, 8'h00, 1);
    endtask

    task automatic test_reset_mid();
        step(1, 8'hE0, 0);
        step(1, 8'hF0, 0);
        do_reset();
        step(0, 8'h00, 0);
        step(1, 8'h1C, 0);
        total++; if (m_tdata !== 10'h01C || m_tvalid !== 1'b1) begin bad++; $display("FAIL reset_mid_event: got v=%b d=%h want 1/01c", m_tvalid, m_tdata); end
        do_reset();
        step(0, 8'h00, 1);
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_out_drop: got %b want 0", m_tvalid); end
    endtask

    task automatic test_back_to_back();
        int bad_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, 8'h10 + 8'(i), 1);
            if (m_tvalid !== 1'b1 || m_tdata !== {2'b00, 8'h10 + 8'(i)}) bad_cycles++;
            step(1, 8'h11 + 8'(i), 1);
            if (m_tvalid !== 1'b0) bad_cycles++;
        end
        total++; if (bad_cycles != 0) begin bad++; $display("FAIL back_to_back: got %0d bad cycles want 0", bad_cycles); end
    endtask

    task automatic test_random();
        int gap = 0;
        bit tv;
        logic [7:0] b;
        int r;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (gap > 0) begin
                gap--;
                tv = 1'b0;
            end else begin
                tv = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 40) == 0) gap = $urandom_range(T - 3, T + 3);
            end
            r = $urandom_range(0, 9);
            if (r < 2)       b = 8'hE0;
            else if (r < 4)  b = 8'hF0;
            else if (r == 4) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
            else             b = 8'($urandom);
            step(tv, b, ($urandom_range(0, 2) != 0));
            total++; if (m_tvalid !== exp_tvalid) begin bad++; $display("FAIL rnd_tvalid @%0d: got %b want %b", i, m_tvalid, exp_tvalid); end
            total++; if (m_tdata !== exp_tdata) begin bad++; $display("FAIL rnd_tdata @%0d: got %h want %h", i, m_tdata, exp_tdata); end
            total++; if (err !== exp_err) begin bad++; $display("FAIL rnd_err @%0d: got %b want %b", i, err, exp_err); end
            total++; if (s_tready !== exp_tready) begin bad++; $display("FAIL rnd_tready @%0d: got %b want %b", i, s_tready, exp_tready); end
        end
    endtask

    initial begin
        test_reset();
        test_plain_make();
        test_ext_release();
        test_backpressure();
        test_timeout();
        test_error_bytes();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kbd_scan_sequencer.md
KBD_SCAN_SEQUENCER -- requirements
Module: kbd_scan_sequencer

Interface
REQ-001 SHALL have parameter PREFIX_TIMEOUT, default 1000, giving the max cycles allowed between prefix bytes of one scan sequence.
REQ-002 SHALL have parameter CNT_WIDTH, default 10, giving the timeout counter width (2^CNT_WIDTH >= PREFIX_TIMEOUT).
REQ-003 SHALL have port axis_aclk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port axis_aresetn_i  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port s_axis_tvalid_i  input  1  raw scan byte valid, from keyboard AXIS source.
REQ-006 SHALL have port s_axis_tready_o  output  1  sequencer accepts a raw byte.
REQ-007 SHALL have port s_axis_tdata_i  input  8  raw PS/2 scan byte.
REQ-008 SHALL have port m_axis_tvalid_o  output  1  key event valid.
REQ-009 SHALL have port m_axis_tready_i  input  1  downstream accepts key event.
REQ-010 SHALL have port m_axis_tdata_o  output  10  event {release[9], extended[8], code[7:0]}.
REQ-011 SHALL have port err_o  output  1  one-cycle pulse on protocol error or timeout.

Function
REQ-012 SHALL implement FSM states IDLE, PFX_E0, PFX_F0, PFX_E0F0, OUT; all outputs registered.
REQ-013 SHALL drive s_axis_tready_o high in IDLE, PFX_E0, PFX_F0 and PFX_E0F0, and low in OUT.
REQ-014 SHALL count a raw byte as accepted only in a cycle with s_axis_tvalid_i and s_axis_tready_o both high.
REQ-015 SHALL, on acceptance of 0xE0: IDLE -> PFX_E0; from PFX_E0, PFX_F0 or PFX_E0F0 -> PFX_E0 with release flag cleared and err_o pulsed (sequence restart).
REQ-016 SHALL, on acceptance of 0xF0: IDLE -> PFX_F0; PFX_E0 -> PFX_E0F0; in PFX_F0 or PFX_E0F0, keep the state and pulse err_o.
REQ-017 SHALL, on acceptance of 0x00 or 0xFF (keyboard overrun/error) in any input state: discard the byte, go to IDLE, pulse err_o, emit no event.
REQ-018 SHALL, on acceptance of any other byte: latch code, set extended = (state is PFX_E0 or PFX_E0F0), set release = (state is PFX_F0 or PFX_E0F0), and go to OUT.
REQ-019 SHALL assert m_axis_tvalid_o with the event in the cycle after the final byte is accepted (latency 1 cycle).
REQ-020 SHALL hold m_axis_tdata_o stable and m_axis_tvalid_o high in OUT until m_axis_tready_i is high, then go to IDLE with tvalid low in the following cycle.
REQ-021 SHALL never drop or duplicate an event; max throughput is one event per 2 cycles.
REQ-022 SHALL clear the timeout counter on entry to any PFX_* state and on every accepted byte, and increment it each PFX_* cycle without acceptance.
REQ-023 SHALL, when the counter reaches PREFIX_TIMEOUT-1 in a PFX_* state with no byte accepted that cycle: go to IDLE, pulse err_o, emit no event.
REQ-024 SHALL, if a byte is accepted in the same cycle the timeout would fire, process the byte and suppress the timeout.
REQ-025 SHALL hold the counter at 0 and not count in IDLE and OUT (no timeout while waiting on m_axis_tready_i).
REQ-026 SHALL drive err_o for exactly one cycle per error event, in the cycle after the triggering condition.

Reset
REQ-027 SHALL, while axis_aresetn_i is low at a clock edge: state = IDLE, m_axis_tvalid_o = 0, m_axis_tdata_o = 0, err_o = 0, counter = 0, s_axis_tready_o = 0.
REQ-028 SHALL drive s_axis_tready_o high from the first cycle after reset deasserts.
REQ-029 SHALL, on reset during any PFX_* state or OUT, discard the partial sequence or pending event, with no event output after reset.

Verification
REQ-030 SHALL verify a plain make: bytes 0x1C -> one event 0x01C; tvalid rises 1 cycle after acceptance.
REQ-031 SHALL verify an extended release: bytes 0xE0, 0xF0, 0x75 -> event 0x375; err_o stays 0.
REQ-032 SHALL verify backpressure: release 0xF0, 0x1C with m_axis_tready_i low for 20 cycles -> event 0x21C held stable, s_axis_tready_o low throughout, one handshake only.
REQ-033 SHALL verify timeout: 0xE0, then idle for PREFIX_TIMEOUT cycles, then 0x1C -> one err_o pulse, then event 0x01C (not extended).
REQ-034 SHALL verify error bytes: 0xF0, 0xFF, 0x1C -> err_o pulse, then event 0x01C; 0xF0, 0xF0 -> err_o pulse, state stays PFX_F0.
REQ-035 SHALL verify reset mid-sequence: 0xE0, 0xF0, then reset pulse, then 0x1C -> event 0x01C only.
